// File: rtl/pong_pkg.sv
// Shared encodings for the Pong round controller: FSM state codes and
// the serve-direction / winner bit meanings.
package pong_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SERVE = 3'd1;
    localparam logic [2:0] PLAY  = 3'd2;
    localparam logic [2:0] POINT = 3'd3;
    localparam logic [2:0] OVER  = 3'd4;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

    localparam logic WINNER_LEFT  = 1'b0;
    localparam logic WINNER_RIGHT = 1'b1;

endpackage : pong_pkg

// File: rtl/pong_round_ctrl.sv
// Match sequencer for Pong: serve delay, live play, point scoring and game
// over. Gates ball motion, recentres the ball and keeps both scores.
module pong_round_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 5,
    parameter int SCORE_W     = 4,
    parameter int SERVE_TICKS = 60,
    parameter int TICK_W      = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               ball_en,
    output logic               ball_center,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         state_dbg
);

    localparam logic [SCORE_W-1:0] WIN_Q      = SCORE_W'(WIN_SCORE);
    localparam logic [TICK_W-1:0]  SERVE_LAST = TICK_W'(SERVE_TICKS - 1);

    logic [2:0]         state_q, state_d;
    logic [TICK_W-1:0]  timer_q, timer_d;
    logic [SCORE_W-1:0] score_left_q, score_left_d;
    logic [SCORE_W-1:0] score_right_q, score_right_d;
    logic               serve_dir_q, serve_dir_d;
    logic               game_over_q, game_over_d;
    logic               winner_q, winner_d;
    logic               ball_en_q, ball_en_d;
    logic               ball_center_q, ball_center_d;

    // The loser of a point serves next, so serve_dir also identifies the scorer
    // while in POINT: a leftward serve means the right player just scored.
    logic scorer_right;
    logic scorer_at_win;

    assign scorer_right  = (serve_dir_q == SERVE_LEFT);
    assign scorer_at_win = scorer_right ? (score_right_q == WIN_Q)
                                        : (score_left_q  == WIN_Q);

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        serve_dir_d   = serve_dir_q;
        game_over_d   = game_over_q;
        winner_d      = winner_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = SERVE;
                    timer_d       = '0;
                    score_left_d  = '0;
                    score_right_d = '0;
                    serve_dir_d   = SERVE_LEFT;
                end
            end

            SERVE: begin
                if (frame_tick) begin
                    if (timer_q == SERVE_LAST) begin
                        state_d = PLAY;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TICK_W'(1);
                    end
                end
            end

            PLAY: begin
                if (miss_left && miss_right) begin
                    state_d = SERVE;
                    timer_d = '0;
                end else if (miss_left) begin
                    state_d       = POINT;
                    serve_dir_d   = SERVE_LEFT;
                    score_right_d = (score_right_q == WIN_Q) ? score_right_q
                                                             : score_right_q + SCORE_W'(1);
                end else if (miss_right) begin
                    state_d      = POINT;
                    serve_dir_d  = SERVE_RIGHT;
                    score_left_d = (score_left_q == WIN_Q) ? score_left_q
                                                           : score_left_q + SCORE_W'(1);
                end
            end

            POINT: begin
                if (scorer_at_win) begin
                    state_d     = OVER;
                    game_over_d = 1'b1;
                    winner_d    = scorer_right ? WINNER_RIGHT : WINNER_LEFT;
                end else begin
                    state_d = SERVE;
                    timer_d = '0;
                end
            end

            OVER: begin
                if (start) begin
                    state_d       = SERVE;
                    timer_d       = '0;
                    score_left_d  = '0;
                    score_right_d = '0;
                    serve_dir_d   = SERVE_LEFT;
                    game_over_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Motion gating follows the current state, so it lags state entry by one cycle.
    assign ball_en_d     = (state_q == PLAY);
    assign ball_center_d = (state_q != PLAY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            score_left_q  <= '0;
            score_right_q <= '0;
            serve_dir_q   <= SERVE_LEFT;
            game_over_q   <= 1'b0;
            winner_q      <= WINNER_LEFT;
            ball_en_q     <= 1'b0;
            ball_center_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            serve_dir_q   <= serve_dir_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
            ball_en_q     <= ball_en_d;
            ball_center_q <= ball_center_d;
        end
    end

    assign ball_en     = ball_en_q;
    assign ball_center = ball_center_q;
    assign serve_dir   = serve_dir_q;
    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;
    assign state_dbg   = state_q;

endmodule : pong_round_ctrl

// File: tb/tb_pong_round_ctrl.sv
// Directed bench for pong_round_ctrl: a vector table for the opening of a
// match plus hand-written sequences for scoring to a win, restart and reset.
module tb_pong_round_ctrl;

    localparam int WIN_SCORE   = 5;
    localparam int SCORE_W     = 4;
    localparam int SERVE_TICKS = 3;
    localparam int TICK_W      = 6;

    logic               clk;
    logic               reset;
    logic               start;
    logic               frame_tick;
    logic               miss_left;
    logic               miss_right;
    logic               ball_en;
    logic               ball_center;
    logic               serve_dir;
    logic [SCORE_W-1:0] score_left;
    logic [SCORE_W-1:0] score_right;
    logic               game_over;
    logic               winner;
    logic [2:0]         state_dbg;

    int total = 0;
    int bad   = 0;

    pong_round_ctrl #(
        .WIN_SCORE  (WIN_SCORE),
        .SCORE_W    (SCORE_W),
        .SERVE_TICKS(SERVE_TICKS),
        .TICK_W     (TICK_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .frame_tick (frame_tick),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .ball_en    (ball_en),
        .ball_center(ball_center),
        .serve_dir  (serve_dir),
        .score_left (score_left),
        .score_right(score_right),
        .game_over  (game_over),
        .winner     (winner),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       st;
        logic       ft;
        logic       ml;
        logic       mr;
        logic [2:0] state;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       be;
        logic       ctr;
        logic       dir;
        logic       go;
        logic       win;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic [3:0] sl,
                           input logic [3:0] sr, input logic be, input logic ctr,
                           input logic dir, input logic go);
        chk({tag, ".state"},  32'(state_dbg),   32'(st));
        chk({tag, ".sl"},     32'(score_left),  32'(sl));
        chk({tag, ".sr"},     32'(score_right), 32'(sr));
        chk({tag, ".ball_en"},32'(ball_en),     32'(be));
        chk({tag, ".center"}, 32'(ball_center), 32'(ctr));
        chk({tag, ".dir"},    32'(serve_dir),   32'(dir));
        chk({tag, ".over"},   32'(game_over),   32'(go));
    endtask

    // Apply inputs for one clock, then sample just after the rising edge.
    task automatic drive(input logic s, input logic ft, input logic ml, input logic mr);
        @(negedge clk);
        start      = s;
        frame_tick = ft;
        miss_left  = ml;
        miss_right = mr;
        @(posedge clk);
        #1;
    endtask

    // Three frame ticks from a fresh SERVE reach PLAY, then one miss cycle.
    task automatic serve_and_miss(input logic ml, input logic mr);
        for (int t = 0; t < SERVE_TICKS; t++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("serve_to_play", 32'(state_dbg), 32'(3'd2));
        drive(1'b0, 1'b0, ml, mr);
    endtask

    initial begin
        // Stimulus columns: start, frame_tick, miss_left, miss_right.
        // Expected: state, score_left, score_right, ball_en, centre, dir, over, winner.
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0, 3'd0, 4'd0,4'd0, 1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0, 3'd1, 4'd0,4'd0, 1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b1,1'b0,1'b0, 3'd1, 4'd0,4'd0, 1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0, 3'd1, 4'd0,4'd0, 1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0, 3'd1, 4'd0,4'd0, 1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b1,1'b1,1'b0, 3'd2, 4'd0,4'd0, 1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0, 3'd2, 4'd0,4'd0, 1'b1,1'b0,1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0, 3'd2, 4'd0,4'd0, 1'b1,1'b0,1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b1, 3'd3, 4'd1,4'd0, 1'b1,1'b0,1'b1,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b0, 3'd1, 4'd1,4'd0, 1'b0,1'b1,1'b1,1'b0,1'b0};
        vecs[10] = '{1'b0,1'b1,1'b0,1'b0, 3'd1, 4'd1,4'd0, 1'b0,1'b1,1'b1,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b1,1'b0,1'b0, 3'd1, 4'd1,4'd0, 1'b0,1'b1,1'b1,1'b0,1'b0};
        vecs[12] = '{1'b0,1'b1,1'b0,1'b0, 3'd2, 4'd1,4'd0, 1'b0,1'b1,1'b1,1'b0,1'b0};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b0, 3'd2, 4'd1,4'd0, 1'b1,1'b0,1'b1,1'b0,1'b0};
        vecs[14] = '{1'b0,1'b1,1'b1,1'b1, 3'd1, 4'd1,4'd0, 1'b1,1'b0,1'b1,1'b0,1'b0};
        vecs[15] = '{1'b0,1'b0,1'b0,1'b0, 3'd1, 4'd1,4'd0, 1'b0,1'b1,1'b1,1'b0,1'b0};

        reset      = 1'b0;
        start      = 1'b0;
        frame_tick = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 3'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reset.winner", 32'(winner), 32'd0);
        $display("reset: state=%0d sl=%0d sr=%0d", state_dbg, score_left, score_right);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].st, vecs[i].ft, vecs[i].ml, vecs[i].mr);
            chk_all($sformatf("vec%0d", i), vecs[i].state, vecs[i].sl, vecs[i].sr,
                    vecs[i].be, vecs[i].ctr, vecs[i].dir, vecs[i].go);
            chk($sformatf("vec%0d.winner", i), 32'(winner), 32'(vecs[i].win));
            $display("vec%0d: in=%b%b%b%b state=%0d sl=%0d sr=%0d be=%0d dir=%0d",
                     i, vecs[i].st, vecs[i].ft, vecs[i].ml, vecs[i].mr,
                     state_dbg, score_left, score_right, ball_en, serve_dir);
        end

        // Right player scores four non-winning points.
        for (int k = 1; k <= 4; k++) begin
            serve_and_miss(1'b1, 1'b0);
            chk_all($sformatf("rpt%0d.point", k), 3'd3, 4'd1, 4'(k), 1'b1, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("rpt%0d.serve", k), 32'(state_dbg), 32'(3'd1));
            $display("rpt%0d: state=%0d sl=%0d sr=%0d", k, state_dbg, score_left, score_right);
        end

        // Winning point for the right player.
        serve_and_miss(1'b1, 1'b0);
        chk_all("win.point", 3'd3, 4'd1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("win.over", 3'd4, 4'd1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("win.winner", 32'(winner), 32'd1);
        $display("win: state=%0d over=%0d winner=%0d", state_dbg, game_over, winner);

        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        chk_all("over.ignore", 3'd4, 4'd1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        $display("over: misses ignored, sl=%0d sr=%0d", score_left, score_right);

        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("restart", 3'd1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        $display("restart: state=%0d sl=%0d sr=%0d", state_dbg, score_left, score_right);

        // Left player takes three points, then reset lands mid-PLAY.
        for (int k = 1; k <= 3; k++) begin
            serve_and_miss(1'b0, 1'b1);
            chk($sformatf("lpt%0d.sl", k), 32'(score_left), 32'(k));
            chk($sformatf("lpt%0d.dir", k), 32'(serve_dir), 32'd1);
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            $display("lpt%0d: state=%0d sl=%0d", k, state_dbg, score_left);
        end
        for (int t = 0; t < SERVE_TICKS; t++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("preReset", 3'd2, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_all("asyncReset", 3'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        $display("asyncReset: state=%0d sl=%0d be=%0d", state_dbg, score_left, ball_en);
        @(negedge clk);
        reset = 1'b1;

        // Serve timer must restart from zero after reset.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("timerClr.serve", 32'(state_dbg), 32'(3'd1));
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("timerClr.play", 32'(state_dbg), 32'(3'd2));
        $display("timerClr: state=%0d", state_dbg);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pong_round_ctrl
